act_broadcast_ctrl: RTL and testbench

ACT_BROADCAST_CTRL -- requirements
Module: act_broadcast_ctrl

---
 rtl/act_broadcast_ctrl.sv | 171 +++++++++++++++++
 tb/tb_act_broadcast_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_broadcast_ctrl.sv
// Activation broadcast controller: reads local activations, broadcasts non-zero ones to the
// router, then signals broadcast finish and, once the layer drains, computation finish.
module act_broadcast_ctrl #(
  parameter int ACT_NO_WIDTH = 6,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              PE_IDX,
  input  logic                    pe_start_calc,
  input  logic [ACT_NO_WIDTH-1:0] in_act_no,
  output logic                    in_act_read_en,
  output logic [ACT_NO_WIDTH-1:0] in_act_read_addr,
  input  logic [DATA_WIDTH-1:0]   in_act_read_data,
  input  logic                    router_rdy,
  input  logic                    fin_broadcast,
  input  logic                    queue_empty,
  input  logic                    mac_busy,
  output logic                    act_send_en,
  output logic [ADDR_WIDTH-1:0]   act_send_addr,
  output logic [DATA_WIDTH-1:0]   act_send_data,
  output logic                    fin_comp,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    SEND      = 3'd2,
    FIN_BC    = 3'd3,
    WAIT_COMP = 3'd4,
    DONE      = 3'd5
  } state_t;

  localparam logic [ACT_NO_WIDTH-1:0] IDX_ZERO = {ACT_NO_WIDTH{1'b0}};
  localparam logic [ACT_NO_WIDTH-1:0] IDX_ONE  = {{(ACT_NO_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r, state_s;
  logic [ACT_NO_WIDTH-1:0] idx_r, idx_s;
  logic [ACT_NO_WIDTH-1:0] cnt_max_r, cnt_max_s;
  logic                    fin_seen_r, fin_seen_s;
  logic [DATA_WIDTH-1:0]   hold_r, hold_s;
  logic                    first_send_r;
  logic                    advance_s;
  logic [5:0]              idx6_s;
  logic                    read_en_s;
  logic                    send_en_s;
  logic [ADDR_WIDTH-1:0]   send_addr_s;
  logic [DATA_WIDTH-1:0]   send_data_s;
  logic                    fin_comp_s;

  // Read data is only valid in the first SEND cycle, so bypass it there and use the hold copy afterwards.
  assign hold_s = first_send_r ? in_act_read_data : hold_r;
  assign idx6_s = 6'(idx_r);

  // Next-state, counters and output strobes.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    cnt_max_s   = cnt_max_r;
    fin_seen_s  = fin_seen_r;
    advance_s   = 1'b0;
    read_en_s   = 1'b0;
    send_en_s   = 1'b0;
    send_addr_s = {ADDR_WIDTH{1'b0}};
    send_data_s = {DATA_WIDTH{1'b0}};
    fin_comp_s  = 1'b0;

    if ((state_r != IDLE) && fin_broadcast) begin
      fin_seen_s = 1'b1;
    end else begin
      fin_seen_s = fin_seen_r;
    end

    case (state_r)
      IDLE: begin
        if (pe_start_calc) begin
          cnt_max_s  = in_act_no;
          idx_s      = IDX_ZERO;
          fin_seen_s = 1'b0;
          state_s    = (in_act_no != IDX_ZERO) ? READ : FIN_BC;
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        read_en_s = 1'b1;
        state_s   = SEND;
      end
      SEND: begin
        if (hold_s == {DATA_WIDTH{1'b0}}) begin
          advance_s = 1'b1;
        end else if (router_rdy) begin
          send_en_s   = 1'b1;
          send_addr_s = ADDR_WIDTH'({4'b0000, idx6_s, PE_IDX});
          send_data_s = hold_s;
          advance_s   = 1'b1;
        end else begin
          advance_s = 1'b0;
        end
        if (advance_s) begin
          if (idx_r == (cnt_max_r - IDX_ONE)) begin
            state_s = FIN_BC;
          end else begin
            idx_s   = idx_r + IDX_ONE;
            state_s = READ;
          end
        end else begin
          state_s = SEND;
        end
      end
      FIN_BC: begin
        if (router_rdy) begin
          send_en_s   = 1'b1;
          send_addr_s = ADDR_WIDTH'({1'b1, 9'b0_0000_0000, PE_IDX});
          state_s     = WAIT_COMP;
        end else begin
          state_s = FIN_BC;
        end
      end
      WAIT_COMP: begin
        // A fin_broadcast pulse arriving this very cycle counts as already seen.
        if ((fin_seen_r || fin_broadcast) && queue_empty && !mac_busy) begin
          state_s = DONE;
        end else begin
          state_s = WAIT_COMP;
        end
      end
      DONE: begin
        if (router_rdy) begin
          fin_comp_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      idx_r        <= IDX_ZERO;
      cnt_max_r    <= IDX_ZERO;
      fin_seen_r   <= 1'b0;
      hold_r       <= {DATA_WIDTH{1'b0}};
      first_send_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      idx_r        <= idx_s;
      cnt_max_r    <= cnt_max_s;
      fin_seen_r   <= fin_seen_s;
      hold_r       <= hold_s;
      first_send_r <= (state_r == READ);
    end
  end

  assign in_act_read_en   = read_en_s;
  assign in_act_read_addr = read_en_s ? idx_r : IDX_ZERO;
  assign act_send_en      = send_en_s;
  assign act_send_addr    = send_addr_s;
  assign act_send_data    = send_data_s;
  assign fin_comp         = fin_comp_s;
  assign busy             = (state_r != IDLE);

endmodule

// File: tb/tb_act_broadcast_ctrl.sv
// Bench for act_broadcast_ctrl: directed scenarios plus randomized layers scored against a
// transaction-level model (expected packet list, read order, finish conditions).
module tb_act_broadcast_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  pe_idx;
  logic        pe_start_calc;
  logic [5:0]  in_act_no;
  logic        in_act_read_en;
  logic [5:0]  in_act_read_addr;
  logic [15:0] in_act_read_data;
  logic        router_rdy;
  logic        fin_broadcast;
  logic        queue_empty;
  logic        mac_busy;
  logic        act_send_en;
  logic [15:0] act_send_addr;
  logic [15:0] act_send_data;
  logic        fin_comp;
  logic        busy;

  always #5 clk = ~clk;

  act_broadcast_ctrl #(.ACT_NO_WIDTH(6), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .PE_IDX(pe_idx), .pe_start_calc(pe_start_calc),
    .in_act_no(in_act_no), .in_act_read_en(in_act_read_en),
    .in_act_read_addr(in_act_read_addr), .in_act_read_data(in_act_read_data),
    .router_rdy(router_rdy), .fin_broadcast(fin_broadcast), .queue_empty(queue_empty),
    .mac_busy(mac_busy), .act_send_en(act_send_en), .act_send_addr(act_send_addr),
    .act_send_data(act_send_data), .fin_comp(fin_comp), .busy(busy)
  );

  // Activation register file: data valid one cycle after the strobe, junk otherwise.
  logic [15:0] mem [64];
  always @(posedge clk) begin
    in_act_read_data <= in_act_read_en ? mem[in_act_read_addr] : 16'($urandom);
  end

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];
  logic [31:0] log_q[$];
  bit  m_busy, m_seen, m_wait, m_armed;
  int  m_rd_idx, m_n;
  int  fin_pkt_cyc, fin_comp_cyc, fin_comp_cnt;
  bit  obs_send, obs_fin;
  logic [15:0] obs_data;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp_v);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_seen = 1'b0; m_wait = 1'b0; m_armed = 1'b0;
    m_rd_idx = 0; m_n = 0;
    exp_q.delete();
  endtask

  // Expected packets of a layer: every non-zero activation in index order, then the finish packet.
  task automatic model_start();
    model_reset();
    m_busy = 1'b1;
    m_n    = int'(in_act_no);
    for (int i = 0; i < m_n; i++) begin
      if (mem[i] != 16'h0000) exp_q.push_back({4'h0, 6'(i), pe_idx, mem[i]});
    end
    exp_q.push_back({1'b1, 9'h000, pe_idx, 16'h0000});
  endtask

  task automatic monitor();
    logic [31:0] pkt;
    logic [31:0] exp_pkt;
    bit fin_pkt_now;
    fin_pkt_now = 1'b0;
    obs_send = act_send_en;
    obs_fin  = fin_comp;
    obs_data = act_send_data;
    check_eq("busy", busy, m_busy);
    if (in_act_read_en) begin
      check_eq("rd_addr", in_act_read_addr, m_rd_idx);
      m_rd_idx++;
    end
    if (act_send_en) begin
      pkt = {act_send_addr, act_send_data};
      log_q.push_back(pkt);
      check_eq("send_rdy", router_rdy, 1'b1);
      check_eq("send_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        exp_pkt = exp_q.pop_front();
        check_eq("send_pkt", pkt, exp_pkt);
        if (exp_pkt[31]) begin
          fin_pkt_now = 1'b1;
          fin_pkt_cyc = cyc;
        end
      end
    end else begin
      check_eq("idle_addr", act_send_addr, 16'h0000);
      check_eq("idle_data", act_send_data, 16'h0000);
    end
    check_eq("fin_comp", fin_comp, m_armed && router_rdy);
    if (fin_comp) check_eq("exclusive", act_send_en, 1'b0);
    // Model state advance at the coming clock edge.
    if (m_busy && fin_broadcast) m_seen = 1'b1;
    if (m_wait && m_seen && queue_empty && !mac_busy) begin
      m_armed = 1'b1;
      m_wait  = 1'b0;
    end
    if (fin_pkt_now) m_wait = 1'b1;
    if (fin_comp) begin
      m_busy = 1'b0; m_armed = 1'b0;
      fin_comp_cyc = cyc;
      fin_comp_cnt++;
    end else if (!m_busy && pe_start_calc) begin
      model_start();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, " busy"}, busy, 1'b0);
    check_eq({tag, " send_en"}, act_send_en, 1'b0);
    check_eq({tag, " addr"}, act_send_addr, 16'h0000);
    check_eq({tag, " data"}, act_send_data, 16'h0000);
    check_eq({tag, " fin_comp"}, fin_comp, 1'b0);
    check_eq({tag, " read_en"}, in_act_read_en, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic start_layer(input int n);
    in_act_no     = 6'(n);
    pe_start_calc = 1'b1;
    fin_broadcast = 1'b0;
    tick();
    pe_start_calc = 1'b0;
  endtask

  // Run until the model expects the layer finished; directed mode pulses fin_broadcast at once.
  task automatic run_layer(input bit rnd, input int budget, input string tag);
    int k;
    k = 0;
    while (m_busy && k < budget) begin
      if (rnd) begin
        router_rdy    = ($urandom_range(0, 9) < 7);
        fin_broadcast = ($urandom_range(0, 15) == 0);
        queue_empty   = ($urandom_range(0, 4) != 0);
        mac_busy      = ($urandom_range(0, 4) == 0);
        pe_start_calc = ($urandom_range(0, 19) == 0);
        in_act_no     = 6'($urandom);
      end else begin
        router_rdy    = 1'b1;
        queue_empty   = 1'b1;
        mac_busy      = 1'b0;
        fin_broadcast = (k == 0);
        pe_start_calc = 1'b0;
      end
      tick();
      k++;
    end
    fin_broadcast = 1'b0;
    pe_start_calc = 1'b0;
    check_eq({tag, " finished"}, m_busy, 1'b0);
    check_eq({tag, " reads"}, m_rd_idx, m_n);
    check_eq({tag, " pkts_left"}, exp_q.size(), 0);
    if (m_busy) do_reset();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc0;
    int fall_cyc;
    pe_idx = 6'd5; rst = 1'b1; pe_start_calc = 1'b0; in_act_no = 6'd0;
    router_rdy = 1'b0; fin_broadcast = 1'b0; queue_empty = 1'b1; mac_busy = 1'b0;
    fin_pkt_cyc = 0; fin_comp_cyc = 0; fin_comp_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Three activations with a zero in the middle.
    mem[0] = 16'd7; mem[1] = 16'd0; mem[2] = 16'd9;
    log_q.delete(); router_rdy = 1'b1;
    start_layer(3);
    run_layer(1'b0, 200, "basic");
    check_eq("basic count", log_q.size(), 3);
    check_eq("basic pkt0", log_q[0], 32'h0005_0007);
    check_eq("basic pkt1", log_q[1], 32'h0085_0009);
    check_eq("basic pkt2", log_q[2], 32'h8005_0000);

    // No activations: the finish packet is the first and only packet.
    log_q.delete();
    start_layer(0);
    run_layer(1'b0, 200, "empty");
    check_eq("empty count", log_q.size(), 1);
    check_eq("empty pkt0", log_q[0], 32'h8005_0000);

    // Backpressure in SEND: data must survive ten stalled cycles.
    mem[0] = 16'd4; log_q.delete(); router_rdy = 1'b0;
    start_layer(1);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("stall no_send", obs_send, 1'b0);
    end
    router_rdy = 1'b1;
    tick();
    check_eq("stall pulse", obs_send, 1'b1);
    check_eq("stall data", obs_data, 16'd4);
    run_layer(1'b0, 200, "stall");
    check_eq("stall count", log_q.size(), 2);

    // fin_broadcast during READ: fin_comp two cycles after the finish packet.
    mem[0] = 16'd1; mem[1] = 16'd2; mem[2] = 16'd3;
    fc0 = fin_comp_cnt;
    start_layer(3);
    run_layer(1'b0, 200, "early_fin");
    check_eq("early_fin gap", fin_comp_cyc - fin_pkt_cyc, 2);
    check_eq("early_fin once", fin_comp_cnt - fc0, 1);

    // MAC still busy after broadcast finished: fin_comp must wait for it.
    fc0 = fin_comp_cnt;
    start_layer(0);
    fin_broadcast = 1'b1; mac_busy = 1'b1; queue_empty = 1'b1; router_rdy = 1'b1;
    tick();
    fin_broadcast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("mac_wait no_fin", obs_fin, 1'b0);
    end
    fall_cyc = cyc;
    run_layer(1'b0, 200, "mac_wait");
    check_eq("mac_wait timing", fin_comp_cyc, fall_cyc + 1);
    check_eq("mac_wait once", fin_comp_cnt - fc0, 1);

    // Reset in SEND, then a clean single-activation layer.
    mem[0] = 16'd5; mem[1] = 16'd6; mem[2] = 16'd7; router_rdy = 1'b0;
    start_layer(3);
    tick();
    tick();
    do_reset();
    mem[0] = 16'd3; log_q.delete(); router_rdy = 1'b1;
    start_layer(1);
    run_layer(1'b0, 200, "restart");
    check_eq("restart count", log_q.size(), 2);
    check_eq("restart pkt0", log_q[0], 32'h0005_0003);
    check_eq("restart pkt1", log_q[1], 32'h8005_0000);

    // Randomized layers.
    for (int t = 0; t < 25; t++) begin
      int n;
      for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 6));
      router_rdy = ($urandom_range(0, 1) == 1);
      start_layer(n);
      run_layer(1'b1, 1500, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
